// File: rtl/cycle_measure_ctrl_if.sv
// Host/CSR and counter-side signal bundle for the cycle measurement sequencer.
// The slave modport is the controller; the master modport is the host plus counter side.
interface cycle_measure_ctrl_if #(
  parameter int unsigned ACC_W = 40
);
  logic             start_req;
  logic [7:0]       run_count;
  logic             abort;
  logic             busy;
  logic             seq_start;
  logic             launch;
  logic             has_tripped;
  logic [31:0]      count1;
  logic [31:0]      count2;
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] sum1;
  logic [ACC_W-1:0] sum2;
  logic [32:0]      last_diff;
  logic [7:0]       runs_done;
  logic             timeout_err;

  modport master (
    output start_req, run_count, abort, has_tripped, count1, count2, res_ready,
    input  busy, seq_start, launch, res_valid, sum1, sum2, last_diff, runs_done, timeout_err
  );

  modport slave (
    input  start_req, run_count, abort, has_tripped, count1, count2, res_ready,
    output busy, seq_start, launch, res_valid, sum1, sum2, last_diff, runs_done, timeout_err
  );
endinterface

// File: rtl/cycle_measure_ctrl.sv
// Batch sequencer for the dual-channel cycle counter: arm, launch, wait for trip or timeout,
// accumulate both channel counts and report the batch over a valid/ready result bus.
module cycle_measure_ctrl #(
  parameter int unsigned ARM_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned ACC_W          = 40
) (
  input logic                 CLK,
  input logic                 RST,
  cycle_measure_ctrl_if.slave bus
);

  localparam int unsigned ARM_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned SUM_W = ACC_W + 1;

  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ACC_W-1:0] ACC_MAX  = {ACC_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_LAUNCH,
    S_WAIT,
    S_ACCUM,
    S_REPORT
  } state_e;

  state_e           state_q,       state_d;
  logic [ARM_W-1:0] arm_cnt_q,     arm_cnt_d;
  logic [TMR_W-1:0] tmr_q,         tmr_d;
  logic [7:0]       runs_tgt_q,    runs_tgt_d;
  logic [7:0]       runs_done_q,   runs_done_d;
  logic [ACC_W-1:0] sum1_q,        sum1_d;
  logic [ACC_W-1:0] sum2_q,        sum2_d;
  logic [32:0]      last_diff_q,   last_diff_d;
  logic             timeout_err_q, timeout_err_d;
  logic             seq_start_q,   seq_start_d;
  logic             launch_q,      launch_d;
  logic             res_valid_q,   res_valid_d;

  logic [SUM_W-1:0] sum1_ext;
  logic [SUM_W-1:0] sum2_ext;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d       = state_q;
    arm_cnt_d     = arm_cnt_q;
    tmr_d         = tmr_q;
    runs_tgt_d    = runs_tgt_q;
    runs_done_d   = runs_done_q;
    sum1_d        = sum1_q;
    sum2_d        = sum2_q;
    last_diff_d   = last_diff_q;
    timeout_err_d = timeout_err_q;

    sum1_ext = {1'b0, sum1_q} + SUM_W'(bus.count1);
    sum2_ext = {1'b0, sum2_q} + SUM_W'(bus.count2);

    case (state_q)
      S_IDLE: begin
        if (bus.start_req) begin
          runs_done_d   = 8'd0;
          sum1_d        = '0;
          sum2_d        = '0;
          last_diff_d   = 33'd0;
          timeout_err_d = 1'b0;
          if (bus.run_count != 8'd0) begin
            runs_tgt_d = bus.run_count;
            arm_cnt_d  = '0;
            state_d    = S_ARM;
          end else begin
            state_d = S_REPORT;
          end
        end
      end
      S_ARM: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (arm_cnt_q == ARM_LAST) begin
          state_d = S_LAUNCH;
        end else begin
          arm_cnt_d = arm_cnt_q + ARM_W'(1);
        end
      end
      S_LAUNCH: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else begin
          tmr_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A trip seen on the final timer cycle still counts as a completed run
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (bus.has_tripped) begin
          state_d = S_ACCUM;
        end else if (tmr_q == TMR_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = S_REPORT;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_ACCUM: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else begin
          sum1_d      = sum1_ext[ACC_W] ? ACC_MAX : sum1_ext[ACC_W-1:0];
          sum2_d      = sum2_ext[ACC_W] ? ACC_MAX : sum2_ext[ACC_W-1:0];
          last_diff_d = {1'b0, bus.count2} - {1'b0, bus.count1};
          runs_done_d = runs_done_q + 8'd1;
          if (runs_done_d == runs_tgt_q) begin
            state_d = S_REPORT;
          end else begin
            arm_cnt_d = '0;
            state_d   = S_ARM;
          end
        end
      end
      S_REPORT: begin
        if (bus.res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Counter is released only while launching or waiting; everything else holds it clear
    seq_start_d = !((state_d == S_LAUNCH) || (state_d == S_WAIT));
    launch_d    = (state_d == S_LAUNCH);
    res_valid_d = (state_d == S_REPORT);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= S_IDLE;
      arm_cnt_q     <= '0;
      tmr_q         <= '0;
      runs_tgt_q    <= 8'd0;
      runs_done_q   <= 8'd0;
      sum1_q        <= '0;
      sum2_q        <= '0;
      last_diff_q   <= 33'd0;
      timeout_err_q <= 1'b0;
      seq_start_q   <= 1'b1;
      launch_q      <= 1'b0;
      res_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      arm_cnt_q     <= arm_cnt_d;
      tmr_q         <= tmr_d;
      runs_tgt_q    <= runs_tgt_d;
      runs_done_q   <= runs_done_d;
      sum1_q        <= sum1_d;
      sum2_q        <= sum2_d;
      last_diff_q   <= last_diff_d;
      timeout_err_q <= timeout_err_d;
      seq_start_q   <= seq_start_d;
      launch_q      <= launch_d;
      res_valid_q   <= res_valid_d;
    end
  end

  assign bus.busy        = (state_q != S_IDLE);
  assign bus.seq_start   = seq_start_q;
  assign bus.launch      = launch_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.sum1        = sum1_q;
  assign bus.sum2        = sum2_q;
  assign bus.last_diff   = last_diff_q;
  assign bus.runs_done   = runs_done_q;
  assign bus.timeout_err = timeout_err_q;

endmodule
